steering_arbiter: RTL
=====================

STEERING_ARBITER -- requirements
Module: steering_arbiter

Interface
REQ-001 Parameter SLEW_STEP, default 4: maximum change of targetDirection per slew tick, in LSB.
REQ-002 Parameter TICK_DIV, default 50000: CLOCK_50 cycles per slew tick (1 kHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 5000000: cycles without an accepted request before falling back to centre (100 ms).
REQ-004 Parameter RECAL_CYCLES, default 16: cycles reset_Pos is held high per recalibration.
REQ-005 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 reqValid  in  3  per-requester command valid; bit0 manual override, bit1 obstacle avoidance, bit2 planner.
REQ-008 reqDir  in  27  three packed 9-bit unsigned directions; bits [9i+8:9i] belong to requester i.
REQ-009 recalReq  in  1  single-cycle request to recalibrate steering position.
REQ-010 reqReady  out  3  one-hot accept strobe, combinational, same cycle as the accepted reqValid.
REQ-011 targetDirection  out  9  registered, slew-limited steering command to the Arduino link.
REQ-012 reset_Pos  out  1  registered recalibration strobe to the Arduino link.
REQ-013 grantId  out  2  registered index of the last accepted requester; 3 = none.
REQ-014 timeout  out  1  registered, high from watchdog expiry until the next accept.

Function
REQ-015 States SHALL be IDLE, TRACK and RECAL.
REQ-016 Outside RECAL, the lowest-indexed requester with reqValid high SHALL be accepted; reqReady SHALL be high for that bit only.
REQ-017 On accept, its reqDir, clamped to MAX_DIR (9'd511, no clamp in practice), SHALL be latched as the internal target at the next edge; grantId SHALL update; timeout SHALL clear; the watchdog SHALL zero; the state SHALL become TRACK.
REQ-018 In IDLE, the internal target SHALL be CENTER (9'd256).
REQ-019 Every TICK_DIV cycles, targetDirection SHALL move toward the target by min(SLEW_STEP, |target - targetDirection|), computed in 10 bits with no wrap-around.
REQ-020 The tick counter SHALL free-run and SHALL NOT restart on accept.
REQ-021 In TRACK, when the watchdog reaches TIMEOUT_CYCLES-1 without an accept, the state SHALL go to IDLE, timeout SHALL rise, and grantId SHALL become 3.
REQ-022 recalReq in IDLE or TRACK SHALL enter RECAL at the next edge and SHALL win over any reqValid in the same cycle, which is then not accepted.
REQ-023 In RECAL: reset_Pos SHALL be 1 for exactly RECAL_CYCLES cycles; targetDirection SHALL be forced to CENTER immediately (no slew); reqReady SHALL be 0; recalReq SHALL be ignored; then the state SHALL go to IDLE with grantId 3.
REQ-024 A new accept in TRACK SHALL retarget mid-slew from the current targetDirection.

Reset
REQ-025 While reset is high at an edge, the block SHALL enter IDLE with: targetDirection = CENTER, reset_Pos = 0, grantId = 3, timeout = 0, all counters zero.
REQ-026 reqReady SHALL be 0 during any cycle in which reset is high.
REQ-027 Reset mid-RECAL or mid-slew SHALL abort immediately, with no residual reset_Pos pulse.

Structure
REQ-028 Package steering_pkg SHALL hold the state enum, CENTER, MAX_DIR, and GRANT_NONE = 2'd3.
REQ-029 Slew arithmetic SHALL live in one sub-module, steering_slew_limiter, with inputs target, tick and force and output the registered position.

Verification
REQ-030 Reset, then planner reqDir = 300 -> reqReady = 3'b100; grantId = 2; targetDirection goes 256, 260, … 300, one step per tick; 11 ticks to settle.
REQ-031 Manual = 100 and planner = 400 in the same cycle -> reqReady = 3'b001; grantId = 0; targetDirection decreases by 4 per tick toward 100.
REQ-032 One accept of 300, then no requests for TIMEOUT_CYCLES -> timeout = 1; grantId = 3; targetDirection slews back to 256.
REQ-033 recalReq together with avoidance reqValid -> reqReady = 0; reset_Pos high for 16 cycles; targetDirection = 256 the next cycle; IDLE afterwards.
REQ-034 Target 2 from 256 with SLEW_STEP = 4 -> final steps end exactly at 2, with no underflow or wrap to 511.
REQ-035 Reset asserted on cycle 5 of RECAL -> reset_Pos = 0 on the next cycle; all outputs at their reset values.

Source files
------------

// File: rtl/steering_pkg.sv
// Shared types and constants for the steering arbiter and its slew limiter.
package steering_pkg;

    localparam int unsigned DIR_W   = 9;
    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        RECAL = 2'd2
    } state_t;

    localparam logic [DIR_W-1:0] CENTER     = 9'd256;
    localparam logic [DIR_W-1:0] MAX_DIR    = 9'd511;
    localparam logic [1:0]       GRANT_NONE = 2'd3;

    // Limit a zero-extended direction to the legal steering range.
    function automatic logic [DIR_W-1:0] clamp_dir(input logic [DIR_W:0] d);
        return (d > 10'(MAX_DIR)) ? MAX_DIR : d[DIR_W-1:0];
    endfunction

endpackage

// File: rtl/steering_slew_limiter.sv
// Registered steering position that walks toward a target by at most SLEW_STEP per tick.
module steering_slew_limiter
    import steering_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIR_W-1:0] target,
    input  logic             tick,
    input  logic             force_center,
    output logic [DIR_W-1:0] position
);

    logic [DIR_W:0] tgt_w;
    logic [DIR_W:0] pos_w;
    logic [DIR_W:0] diff;
    logic [DIR_W:0] step;
    logic [DIR_W:0] pos_next;
    logic           up;

    // One extra bit keeps the difference and the stepped value free of wrap-around.
    always_comb begin
        tgt_w    = {1'b0, target};
        pos_w    = {1'b0, position};
        up       = (tgt_w >= pos_w);
        diff     = up ? (tgt_w - pos_w) : (pos_w - tgt_w);
        step     = (diff > 10'(SLEW_STEP)) ? 10'(SLEW_STEP) : diff;
        pos_next = up ? (pos_w + step) : (pos_w - step);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            position <= CENTER;
        end else if (force_center) begin
            position <= CENTER;
        end else if (tick) begin
            position <= pos_next[DIR_W-1:0];
        end
    end

endmodule

// File: rtl/steering_arbiter.sv
// Fixed-priority steering command arbiter with watchdog fallback and position recalibration.
module steering_arbiter
    import steering_pkg::*;
#(
    parameter int unsigned SLEW_STEP      = 4,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned RECAL_CYCLES   = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ*DIR_W-1:0] reqDir,
    input  logic                     recalReq,
    output logic [NUM_REQ-1:0]       reqReady,
    output logic [DIR_W-1:0]         targetDirection,
    output logic                     reset_Pos,
    output logic [1:0]               grantId,
    output logic                     timeout
);

    localparam int unsigned CNT_W = 32;

    state_t             state;
    state_t             state_n;
    logic [DIR_W-1:0]   target_q;
    logic [DIR_W-1:0]   target_n;
    logic [1:0]         grant_n;
    logic               timeout_n;
    logic [CNT_W-1:0]   wd_cnt;
    logic [CNT_W-1:0]   wd_n;
    logic [CNT_W-1:0]   rc_cnt;
    logic [CNT_W-1:0]   rc_n;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               accept;
    logic [1:0]         acc_id;
    logic [DIR_W-1:0]   acc_dir;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Lowest index wins; recalibration, reset and RECAL block every accept.
    always_comb begin
        reqReady = '0;
        accept   = 1'b0;
        acc_id   = GRANT_NONE;
        acc_dir  = CENTER;
        if (!reset && state != RECAL && !recalReq) begin
            if (reqValid[0]) begin
                reqReady = 3'b001;
                accept   = 1'b1;
                acc_id   = 2'd0;
                acc_dir  = clamp_dir({1'b0, reqDir[DIR_W-1:0]});
            end else if (reqValid[1]) begin
                reqReady = 3'b010;
                accept   = 1'b1;
                acc_id   = 2'd1;
                acc_dir  = clamp_dir({1'b0, reqDir[2*DIR_W-1:DIR_W]});
            end else if (reqValid[2]) begin
                reqReady = 3'b100;
                accept   = 1'b1;
                acc_id   = 2'd2;
                acc_dir  = clamp_dir({1'b0, reqDir[3*DIR_W-1:2*DIR_W]});
            end
        end
    end

    always_comb begin
        state_n   = state;
        target_n  = target_q;
        grant_n   = grantId;
        timeout_n = timeout;
        wd_n      = wd_cnt;
        rc_n      = rc_cnt;
        if (state == RECAL) begin
            if (rc_cnt == CNT_W'(RECAL_CYCLES - 1)) begin
                state_n  = IDLE;
                grant_n  = GRANT_NONE;
                rc_n     = '0;
            end else begin
                rc_n = rc_cnt + 1'b1;
            end
        end else if (recalReq) begin
            state_n  = RECAL;
            target_n = CENTER;
            rc_n     = '0;
            wd_n     = '0;
        end else if (accept) begin
            state_n   = TRACK;
            target_n  = acc_dir;
            grant_n   = acc_id;
            timeout_n = 1'b0;
            wd_n      = '0;
        end else if (state == TRACK) begin
            if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_n   = IDLE;
                target_n  = CENTER;
                grant_n   = GRANT_NONE;
                timeout_n = 1'b1;
                wd_n      = '0;
            end else begin
                wd_n = wd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            target_q  <= CENTER;
            grantId   <= GRANT_NONE;
            timeout   <= 1'b0;
            wd_cnt    <= '0;
            rc_cnt    <= '0;
            tick_cnt  <= '0;
            reset_Pos <= 1'b0;
        end else begin
            state     <= state_n;
            target_q  <= target_n;
            grantId   <= grant_n;
            timeout   <= timeout_n;
            wd_cnt    <= wd_n;
            rc_cnt    <= rc_n;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            reset_Pos <= (state_n == RECAL);
        end
    end

    steering_slew_limiter #(
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk          (CLOCK_50),
        .reset        (reset),
        .target       (target_q),
        .tick         (tick),
        .force_center (state_n == RECAL),
        .position     (targetDirection)
    );

endmodule
